// File: rtl/async_tx_serializer.sv
// Asynchronous serial transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// One baud_tick pulse marks each bit boundary; all outputs come straight from flops.
module async_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t                state_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [3:0]            bit_cnt_r;
  logic                  stop_cnt_r;
  logic                  par_en_r;
  logic                  par_bit_r;
  logic                  tx_r;
  logic                  busy_r;
  logic                  done_r;

  // Even parity is the XOR of the data; odd parity inverts it.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // Frame sequencer: one state step per baud_tick once a request is accepted.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      bit_cnt_r  <= 4'd0;
      stop_cnt_r <= 1'b0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          tx_r <= 1'b1;
          if (tx_start) begin
            shift_r   <= tx_data;
            par_en_r  <= parity_en;
            par_bit_r <= calc_parity(tx_data, parity_odd);
            busy_r    <= 1'b1;
            state_r   <= ARM;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ARM: begin
          if (baud_tick) begin
            tx_r    <= 1'b0;
            state_r <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            tx_r      <= shift_r[0];
            shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
            bit_cnt_r <= 4'd0;
            state_r   <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt_r == LAST_BIT) begin
              if (par_en_r) begin
                tx_r    <= par_bit_r;
                state_r <= PARITY;
              end else begin
                tx_r       <= 1'b1;
                stop_cnt_r <= 1'b0;
                state_r    <= STOP;
              end
            end else begin
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            tx_r       <= 1'b1;
            stop_cnt_r <= 1'b0;
            state_r    <= STOP;
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (stop_cnt_r == LAST_STOP) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end
          end
        end
        default: begin
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_async_tx_serializer.sv
// Self-checking bench: frames are predicted as bit lists (start, data LSB first, parity, stops)
// and compared cycle by cycle against two instances (1 and 2 stop bits).
module tb_async_tx_serializer;

  localparam int DW       = 8;
  localparam int TICK_PER = 4;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          baud_tick = 1'b0;
  logic          tx_start = 1'b0;
  logic          tx_start2 = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          tx, busy, done;
  logic          tx2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  async_tx_serializer #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .baud_tick(baud_tick), .tx_start(tx_start),
    .tx_data(tx_data), .parity_en(parity_en), .parity_odd(parity_odd),
    .tx(tx), .busy(busy), .done(done)
  );

  async_tx_serializer #(.DATA_WIDTH(DW), .STOP_BITS(2)) dut2 (
    .clk_in(clk_in), .rst_n(rst_n), .baud_tick(baud_tick), .tx_start(tx_start2),
    .tx_data(tx_data), .parity_en(parity_en), .parity_odd(parity_odd),
    .tx(tx2), .busy(busy2), .done(done2)
  );

  always #5 clk_in = ~clk_in;

  // One clock cycle from negedge to negedge; baud_tick fires every TICK_PER cycles.
  task automatic step();
    baud_tick = (tick_cnt == TICK_PER - 1);
    tick_cnt  = (tick_cnt + 1) % TICK_PER;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // mode 0: random lead-in, 1: accept on a tick cycle, 2: accept immediately.
  task automatic check_frame(input bit which, input logic [DW-1:0] d, input logic pen,
                             input logic podd, input int mode, input bit inject);
    bit   bits[$];
    int   nb, ticks, n;
    bit   is_tick, fin;
    logic exp_tx, exp_busy, exp_done, o_tx, o_busy, o_done;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((^d) ^ podd);
    for (int i = 0; i < (which ? 2 : 1); i++) bits.push_back(1'b1);
    nb = bits.size();
    if (mode == 1) begin
      n = 0;
      while (tick_cnt != TICK_PER - 1 && n < 8) begin step(); n++; end
    end else if (mode == 0) begin
      n = $urandom_range(0, 3);
      repeat (n) step();
    end
    tx_data = d; parity_en = pen; parity_odd = podd;
    if (which) tx_start2 = 1'b1; else tx_start = 1'b1;
    step();
    tx_start = 1'b0; tx_start2 = 1'b0;
    tx_data = DW'($urandom); parity_en = 1'($urandom); parity_odd = 1'($urandom);
    o_tx = which ? tx2 : tx; o_busy = which ? busy2 : busy;
    checks++;
    if (o_busy !== 1'b1 || o_tx !== 1'b1) begin
      errors++;
      $display("FAIL accept busy=%b tx=%b expected busy=1 tx=1", o_busy, o_tx);
    end
    ticks = 0; fin = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      is_tick = (tick_cnt == TICK_PER - 1);
      if (inject && ticks == 3 && !is_tick) begin
        tx_data = 8'hFF;
        if (which) tx_start2 = 1'b1; else tx_start = 1'b1;
      end
      step();
      tx_start = 1'b0; tx_start2 = 1'b0;
      if (is_tick) ticks++;
      exp_tx   = (ticks == 0 || ticks > nb) ? 1'b1 : bits[ticks-1];
      exp_done = (ticks == nb + 1);
      exp_busy = (ticks <= nb);
      o_tx   = which ? tx2 : tx;
      o_busy = which ? busy2 : busy;
      o_done = which ? done2 : done;
      checks++;
      if (o_tx !== exp_tx) begin
        errors++;
        $display("FAIL frame_tx data=%h tick=%0d got=%b exp=%b", d, ticks, o_tx, exp_tx);
      end
      checks++;
      if (o_busy !== exp_busy) begin
        errors++;
        $display("FAIL frame_busy data=%h tick=%0d got=%b exp=%b", d, ticks, o_busy, exp_busy);
      end
      checks++;
      if (o_done !== exp_done) begin
        errors++;
        $display("FAIL frame_done data=%h tick=%0d got=%b exp=%b", d, ticks, o_done, exp_done);
      end
      fin = (ticks == nb + 1);
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL frame_timeout data=%h ticks=%0d of %0d", d, ticks, nb + 1);
    end
  endtask

  task automatic check_idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      step();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0) begin
        errors++;
        $display("FAIL idle tx=%b busy=%b done=%b tx2=%b busy2=%b expected 1 0 0 1 0",
                 tx, busy, done, tx2, busy2);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_start = 1'b1;
    #12;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state tx=%b busy=%b done=%b tx2=%b busy2=%b done2=%b expected 1 0 0 1 0 0",
               tx, busy, done, tx2, busy2, done2);
    end
    @(negedge clk_in);
    tx_start = 1'b0;
    rst_n = 1'b1;
    check_idle(6);
  endtask

  task automatic test_reset_mid();
    int ticks, n;
    n = $urandom_range(0, 3);
    repeat (n) step();
    tx_data = 8'h35; parity_en = 1'b0; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    ticks = 0; n = 0;
    while (ticks < 5 && n < 100) begin
      if (tick_cnt == TICK_PER - 1) ticks++;
      step();
      n++;
    end
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_bit3 tx=%b busy=%b expected tx=0 busy=1", tx, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset tx=%b busy=%b done=%b expected 1 0 0", tx, busy, done);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    check_idle(20);
  endtask

  initial begin
    test_reset();
    // basic 0x55, no parity
    check_frame(1'b0, 8'h55, 1'b0, 1'b0, 0, 1'b0);
    check_idle(3);
    // parity even then odd
    check_frame(1'b0, 8'hA5, 1'b1, 1'b0, 0, 1'b0);
    check_frame(1'b0, 8'hA5, 1'b1, 1'b1, 0, 1'b0);
    // two stop bits
    check_frame(1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    check_idle(3);
    // mid-frame request dropped, then nothing pending
    check_frame(1'b0, 8'h3A, 1'b0, 1'b0, 0, 1'b1);
    check_idle(12);
    // back to back: request in the done cycle
    check_frame(1'b0, 8'h96, 1'b0, 1'b0, 0, 1'b0);
    check_frame(1'b0, 8'h69, 1'b1, 1'b1, 2, 1'b0);
    check_frame(1'b1, 8'hC3, 1'b1, 1'b0, 2, 1'b0);
    // start coincident with a tick
    check_frame(1'b0, 8'hE7, 1'b0, 1'b0, 1, 1'b0);
    check_frame(1'b1, 8'h18, 1'b1, 1'b1, 1, 1'b0);
    test_reset_mid();
    // randomized frames
    for (int k = 0; k < 20; k++) begin
      check_frame(1'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2), 1'($urandom));
    end
    check_idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_tx_serializer.md
# async_tx_serializer

Serial transmit engine for the asynchronous data link. It consumes the bit-rate enable derived from the programmable clock divider and shifts a parallel word onto a single line, LSB first. Each frame carries a start bit, the data bits, an optional even/odd parity bit, and 1 or 2 stop bits. It sits directly downstream of the divider: one `baud_tick` pulse marks each bit boundary.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame; legal values 5–9.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `clk_in`  input  1  system clock; all logic rises on its posedge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `baud_tick`  input  1  one-`clk_in`-cycle pulse per bit period.
- `tx_start`  input  1  request to send `tx_data`; sampled only when `busy`=0.
- `tx_data`  input  DATA_WIDTH  word to send.
- `parity_en`  input  1  1 = insert a parity bit after the data bits.
- `parity_odd`  input  1  1 = odd parity, 0 = even parity.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  a frame is accepted or in progress.
- `done`  output  1  one-cycle pulse at end of frame.

## Operation
- Reset (async assert, any state): `tx`=1, `busy`=0, `done`=0, FSM=IDLE, bit counter=0, shift register=0.
- FSM states:
  - IDLE: wait for a request.
  - ARM: wait for the first tick.
  - START, DATA, PARITY, STOP: the frame bits.
- IDLE:
  - On `tx_start`=1: latch `tx_data`, `parity_en` and `parity_odd` into internal registers; go to ARM; `busy`=1 next cycle.
  - `tx` stays 1.
  - A `baud_tick` in the same cycle as acceptance is not consumed.
- ARM: on `baud_tick`, `tx`<=0 and go to START.
- START: on `baud_tick`, `tx`<=data bit 0 and go to DATA with bit counter=0.
- DATA:
  - Each `baud_tick` advances the counter and drives the next bit, LSB first.
  - On the tick after bit DATA_WIDTH-1: go to PARITY if latched `parity_en`=1; otherwise go to STOP with `tx`<=1.
- PARITY:
  - The bit driven on entry is the XOR of all latched data bits, inverted when latched `parity_odd`=1.
  - On the next `baud_tick`: go to STOP with `tx`<=1.
- STOP:
  - Held for STOP_BITS tick periods; stop-bit counter width is 1.
  - On the tick ending the last stop bit: `done`<=1 for one cycle, `busy`<=0, go to IDLE.
- `tx_start` while `busy`=1 is ignored; there is no queueing.
- Changes to `tx_data`, `parity_en` or `parity_odd` after acceptance do not affect the frame in flight.
- Parity is computed at acceptance and stored in a 1-bit register.
- `tx` is driven straight from a flop, with no combinational path to the output.

## Timing
- Every output is registered; changes appear on the `clk_in` edge that samples the causing input.
- Acceptance to `busy`=1: 1 cycle.
- Acceptance to `tx` falling: the first `baud_tick` strictly after acceptance, plus 1 cycle.
- Frame length in ticks after ARM: 1 + DATA_WIDTH + parity_en + STOP_BITS.
  - Default config: 10 ticks without parity, 11 with.
- `done` and `busy` falling happen in the same cycle.
- A new `tx_start` is accepted in the cycle where `done`=1, since `busy`=0 then. Back-to-back frames have no idle bit beyond the ARM wait.
- `baud_tick` held high for consecutive cycles is treated as one tick per cycle. The divider guarantees single-cycle pulses.
- `rst_n` deasserted mid-frame:
  - The line returns high within the reset assertion.
  - No `done` is produced.
  - The first frame after reset needs a fresh `tx_start`.

## Test plan
- Reset, then hold `baud_tick` every 4 cycles and send 0x55 with no parity.
  - `tx` per tick: 0, 1,0,1,0,1,0,1,0, 1.
  - `done` pulses once; `busy` high for exactly 10 tick periods plus the ARM wait.
- Send 0xA5 with even parity, then again with odd parity.
  - Data bits 1,0,1,0,0,1,0,1.
  - Parity bit 0 with even parity, 1 with odd parity.
  - 11-tick frame.
- `STOP_BITS`=2, send 0x00.
  - `tx` low for 9 tick periods, then high for 2 periods before `done`.
- Pulse `tx_start` with 0xFF mid-frame, and change `tx_data` after acceptance.
  - The frame in flight is unchanged.
  - The second request is dropped.
  - Re-asserting `tx_start` in the `done` cycle starts a new frame at the next tick.
- Assert `rst_n`=0 during data bit 3.
  - `tx`=1, `busy`=0, `done`=0 immediately, with no clock edge.
  - After release, `tx` stays 1 with no `tx_start`.
- Raise `tx_start` and `baud_tick` in the same cycle.
  - The start bit begins on the following tick, not the coincident one.
